biu_lsu_resp: RTL and testbench

- Responder end of the LSU↔BIU packet interface.
- Accepts one request packet at a time from the load/store unit and performs it on a simple single-outstanding memory port.
- Returns response packets: multi-beat line fills, single-beat uncached loads, and store completions.
- Sits in the BIU between the core LSU and the memory/bus fabric.

---
 rtl/biu_pkg.sv | 59 +++++
 rtl/biu_lsu_resp.sv | 165 ++++++++++++++++
 tb/tb_biu_lsu_resp.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biu_pkg.sv
// Shared LSU<->BIU packet layout, state encoding and store lane helpers.
// The packet macros live here so every file compiled after this one sees them.
`ifndef BIU_PKT_DEFINES
`define BIU_PKT_DEFINES
`define PKT_DATA       63:0
`define PKT_ADDR       95:64
`define PKT_ADDR_W     32
`define PKT_TYPE       97:96
`define PKT_LAST       98
`define PKT_SIZE       101:99
`define PKT_VLD        102
`define PKT_BITS       103
`define PKT_TYPE_LOAD  2'b01
`define PKT_TYPE_STORE 2'b10
`define REQ_SZ_BYTE    3'd0
`define REQ_SZ_WORD    3'd1
`define REQ_SZ_LWRD    3'd2
`define REQ_SZ_QWRD    3'd3
`define REQ_SZ_LINE    3'd4
`endif

package biu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MREQ,
    ST_MWAIT,
    ST_SRSP
  } state_e;

  localparam int PKT_W       = `PKT_BITS;
  localparam int PKT_VLD_BIT = `PKT_VLD;

  localparam logic [1:0] TYPE_LOAD  = `PKT_TYPE_LOAD;
  localparam logic [1:0] TYPE_STORE = `PKT_TYPE_STORE;

  localparam logic [2:0] SZ_BYTE = `REQ_SZ_BYTE;
  localparam logic [2:0] SZ_WORD = `REQ_SZ_WORD;
  localparam logic [2:0] SZ_LWRD = `REQ_SZ_LWRD;
  localparam logic [2:0] SZ_QWRD = `REQ_SZ_QWRD;
  localparam logic [2:0] SZ_LINE = `REQ_SZ_LINE;

  // A single-beat line still needs a one-bit counter to exist.
  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic logic [7:0] size_to_be(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] mask;
    case (size)
      SZ_BYTE: mask = 8'h01;
      SZ_WORD: mask = 8'h03;
      SZ_LWRD: mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << off;
  endfunction

endpackage

// File: rtl/biu_lsu_resp.sv
// BIU responder for LSU request packets: runs each request on a single-outstanding
// memory port and returns line-fill, uncached-load and store-completion packets.
module biu_lsu_resp
  import biu_pkg::*;
#(
  parameter int LINE_BEATS = 2,
  parameter int PA_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [`PKT_BITS-1:0] lsu_req_pkt_xx,
  output logic                 lsu_req_ack_xx,
  output logic [`PKT_BITS-1:0] biu_resp_pkt_xx,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [PA_W-1:0]      mem_addr,
  output logic [63:0]          mem_wdata,
  output logic [7:0]           mem_be,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [63:0]          mem_rdata
);

  localparam int              CNT_W         = beat_cnt_w(LINE_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(LINE_BEATS - 1);
  localparam logic [PA_W-1:0] LINE_OFS_MASK = PA_W'(LINE_BEATS * 8 - 1);

  state_e               state_q, state_d;
  logic                 is_store_q, is_store_d;
  logic                 is_line_q, is_line_d;
  logic [PA_W-1:0]      req_addr_q, req_addr_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [PA_W-1:0]      mem_addr_q, mem_addr_d;
  logic [63:0]          mem_wdata_q, mem_wdata_d;
  logic [7:0]           mem_be_q, mem_be_d;
  logic [`PKT_BITS-1:0] resp_q, resp_d;

  logic [PA_W-1:0] pkt_addr;
  logic [1:0]      pkt_type;
  logic [2:0]      pkt_size;
  logic [63:0]     pkt_data;
  logic            pkt_is_load;
  logic            pkt_is_store;
  logic            unused_req_last;

  assign pkt_addr        = PA_W'(lsu_req_pkt_xx[`PKT_ADDR]);
  assign pkt_type        = lsu_req_pkt_xx[`PKT_TYPE];
  assign pkt_size        = lsu_req_pkt_xx[`PKT_SIZE];
  assign pkt_data        = lsu_req_pkt_xx[`PKT_DATA];
  assign pkt_is_load     = (pkt_type == TYPE_LOAD);
  assign pkt_is_store    = (pkt_type == TYPE_STORE);
  assign unused_req_last = lsu_req_pkt_xx[`PKT_LAST];

  // Unacked requests are simply lost, so ack must be exact in the request cycle.
  assign lsu_req_ack_xx = lsu_req_pkt_xx[`PKT_VLD] & (pkt_is_load | pkt_is_store) &
                          (state_q == ST_IDLE) & ~reset;

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    is_line_d   = is_line_q;
    req_addr_d  = req_addr_q;
    beat_d      = beat_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    resp_d      = '0;

    case (state_q)
      ST_IDLE: begin
        if (lsu_req_ack_xx) begin
          state_d     = ST_MREQ;
          is_store_d  = pkt_is_store;
          is_line_d   = pkt_is_load && (pkt_size == SZ_LINE);
          req_addr_d  = pkt_addr;
          beat_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = pkt_is_store;
          mem_addr_d  = (pkt_is_load && (pkt_size == SZ_LINE)) ? (pkt_addr & ~LINE_OFS_MASK)
                                                               : {pkt_addr[PA_W-1:3], 3'b000};
          mem_wdata_d = pkt_is_store ? (pkt_data << {pkt_addr[2:0], 3'b000}) : 64'h0;
          mem_be_d    = pkt_is_store ? size_to_be(pkt_size, pkt_addr[2:0]) : 8'h00;
        end
      end
      ST_MREQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (is_store_q) begin
            state_d                = ST_SRSP;
            resp_d[`PKT_VLD]       = 1'b1;
            resp_d[`PKT_TYPE]      = TYPE_STORE;
            resp_d[`PKT_LAST]      = 1'b1;
            resp_d[`PKT_ADDR]      = `PKT_ADDR_W'(req_addr_q);
          end else begin
            state_d = ST_MWAIT;
          end
        end
      end
      ST_MWAIT: begin
        if (mem_rvalid) begin
          resp_d[`PKT_VLD]  = 1'b1;
          resp_d[`PKT_TYPE] = TYPE_LOAD;
          resp_d[`PKT_LAST] = is_line_q ? (beat_q == LAST_BEAT) : 1'b1;
          resp_d[`PKT_ADDR] = `PKT_ADDR_W'(is_line_q ? mem_addr_q : req_addr_q);
          resp_d[`PKT_DATA] = mem_rdata;
          // Line beats are fetched in ascending order from the aligned base.
          if (is_line_q && (beat_q != LAST_BEAT)) begin
            state_d    = ST_MREQ;
            beat_d     = beat_q + CNT_W'(1);
            mem_req_d  = 1'b1;
            mem_addr_d = mem_addr_q + PA_W'(8);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SRSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      is_store_q  <= 1'b0;
      is_line_q   <= 1'b0;
      req_addr_q  <= '0;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      is_line_q   <= is_line_d;
      req_addr_q  <= req_addr_d;
      beat_q      <= beat_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      resp_q      <= resp_d;
    end
  end

  assign biu_resp_pkt_xx = resp_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_be          = mem_be_q;

endmodule

// File: tb/tb_biu_lsu_resp.sv
// Randomized bench for biu_lsu_resp: a transaction-level model turns each accepted
// request into expected memory operations and response packets.
module tb_biu_lsu_resp;
  import biu_pkg::*;

  localparam int LB = 2;
  localparam int PW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [PKT_W-1:0] lsu_req_pkt_xx;
  logic             lsu_req_ack_xx;
  logic [PKT_W-1:0] biu_resp_pkt_xx;
  logic             mem_req;
  logic             mem_we;
  logic [PW-1:0]    mem_addr;
  logic [63:0]      mem_wdata;
  logic [7:0]       mem_be;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [63:0]      mem_rdata;

  always #5 clk = ~clk;

  biu_lsu_resp #(.LINE_BEATS(LB), .PA_W(PW)) dut (
    .clk             (clk),
    .reset           (reset),
    .lsu_req_pkt_xx  (lsu_req_pkt_xx),
    .lsu_req_ack_xx  (lsu_req_ack_xx),
    .biu_resp_pkt_xx (biu_resp_pkt_xx),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_be          (mem_be),
    .mem_gnt         (mem_gnt),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } memop_t;

  memop_t           op_q[$];
  logic [PKT_W-1:0] resp_exp_q[$];

  int          errors = 0;
  int          checks = 0;
  bit          busy = 0;
  int          release_cnt = 0;
  bit          resp_due = 0;
  int          gnt_wait = 0;
  bit          rd_pending = 0;
  int          rd_cnt = 0;
  logic [31:0] rd_addr = '0;
  int          fixed_gnt = -1;
  int          fixed_rd = -1;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] memWord(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a + 32'h0000_1357};
  endfunction

  // Packet order, MSB first: VLD, SIZE, LAST, TYPE, ADDR, DATA.
  function automatic logic [PKT_W-1:0] mkPkt(input logic [2:0] size, input logic last,
                                             input logic [1:0] typ, input logic [31:0] a,
                                             input logic [63:0] d);
    return {1'b1, size, last, typ, a, d};
  endfunction

  function automatic logic [7:0] sizeBytes(input logic [2:0] size);
    case (size)
      SZ_BYTE: return 8'h01;
      SZ_WORD: return 8'h03;
      SZ_LWRD: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic modelAccept(input logic [PKT_W-1:0] pkt);
    logic [2:0]  size;
    logic [1:0]  typ;
    logic [31:0] a, aligned, base;
    logic [63:0] d;
    logic [15:0] wide_be;
    memop_t      op;
    size    = pkt[101:99];
    typ     = pkt[97:96];
    a       = pkt[95:64];
    d       = pkt[63:0];
    aligned = a - 32'(a % 8);
    if (typ == TYPE_STORE) begin
      wide_be  = 16'(sizeBytes(size)) * (16'd1 << a[2:0]);
      op.we    = 1'b1;
      op.addr  = aligned;
      op.be    = wide_be[7:0];
      op.wdata = d << (8 * a[2:0]);
      op_q.push_back(op);
      resp_exp_q.push_back(mkPkt(3'd0, 1'b1, TYPE_STORE, a, 64'h0));
    end else if (size == SZ_LINE) begin
      base = a - 32'(a % (LB * 8));
      for (int i = 0; i < LB; i++) begin
        op.we    = 1'b0;
        op.addr  = base + 32'(8 * i);
        op.be    = 8'h00;
        op.wdata = 64'h0;
        op_q.push_back(op);
        resp_exp_q.push_back(mkPkt(3'd0, (i == LB - 1), TYPE_LOAD, op.addr, memWord(op.addr)));
      end
    end else begin
      op.we    = 1'b0;
      op.addr  = aligned;
      op.be    = 8'h00;
      op.wdata = 64'h0;
      op_q.push_back(op);
      resp_exp_q.push_back(mkPkt(3'd0, 1'b1, TYPE_LOAD, a, memWord(aligned)));
    end
  endtask

  function automatic logic [PKT_W-1:0] randReq();
    logic [1:0] typ;
    int         r;
    r = $urandom_range(0, 9);
    typ = (r == 0) ? ($urandom_range(0, 1) ? 2'b11 : 2'b00) : ((r < 5) ? TYPE_LOAD : TYPE_STORE);
    return {($urandom_range(0, 9) != 0), 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
            typ, 32'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  // One clock cycle: check last edge's outputs, play memory, offer a request.
  task automatic applyStimulus(input bit req_en, input logic [PKT_W-1:0] req);
    logic [PKT_W-1:0] exp_pkt;
    bit               exp_req;
    bit               exp_ack;
    memop_t           cur;
    if (resp_due) begin
      exp_pkt = (resp_exp_q.size() != 0) ? resp_exp_q.pop_front() : '0;
      checkOutput("resp_pkt", biu_resp_pkt_xx, exp_pkt);
    end else begin
      checkOutput("resp_quiet", biu_resp_pkt_xx[PKT_VLD_BIT], 1'b0);
    end
    resp_due = 0;
    if (release_cnt > 0) begin
      release_cnt--;
      if (release_cnt == 0) busy = 0;
    end

    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = {$urandom, $urandom};
    exp_req    = (op_q.size() != 0) && !rd_pending;
    checkOutput("mem_req", mem_req, exp_req);
    if (rd_pending) begin
      if (rd_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memWord(rd_addr);
        rd_pending = 0;
        resp_due   = 1;
        if (op_q.size() == 0) release_cnt = 1;
      end else begin
        rd_cnt--;
      end
    end else if (exp_req && mem_req) begin
      cur = op_q[0];
      checkOutput("mem_we", mem_we, cur.we);
      checkOutput("mem_addr", mem_addr, cur.addr);
      if (cur.we) begin
        checkOutput("mem_be", mem_be, cur.be);
        checkOutput("mem_wdata", mem_wdata, cur.wdata);
      end
      if (gnt_wait == 0) begin
        mem_gnt = 1'b1;
        void'(op_q.pop_front());
        if (cur.we) begin
          resp_due    = 1;
          release_cnt = 2;
        end else begin
          rd_pending = 1;
          rd_cnt     = (fixed_rd >= 0) ? fixed_rd : $urandom_range(0, 3);
          rd_addr    = cur.addr;
        end
        gnt_wait = (fixed_gnt >= 0) ? fixed_gnt : $urandom_range(0, 5);
      end else begin
        gnt_wait--;
      end
    end else begin
      mem_rvalid = ($urandom_range(0, 5) == 0);
    end

    lsu_req_pkt_xx = req_en ? req : '0;
    exp_ack = req_en && req[PKT_VLD_BIT] && !busy &&
              ((req[97:96] == TYPE_LOAD) || (req[97:96] == TYPE_STORE));
    #1;
    checkOutput("ack", lsu_req_ack_xx, exp_ack);
    if (exp_ack) begin
      modelAccept(req);
      busy = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 80; i++) begin
      if (!busy && !resp_due && (op_q.size() == 0) && (resp_exp_q.size() == 0)) return;
      applyStimulus(1'b0, '0);
    end
    checkOutput("drain_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    lsu_req_pkt_xx = mkPkt(SZ_LINE, 1'b0, TYPE_LOAD, 32'h40, 64'h0);
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 64'h0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("rst_ack", lsu_req_ack_xx, 1'b0);
    checkOutput("rst_resp", biu_resp_pkt_xx, '0);
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_mem_we", mem_we, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, '0);
    checkOutput("rst_mem_be", mem_be, '0);
    checkOutput("rst_mem_wdata", mem_wdata, '0);
    reset          = 1'b0;
    lsu_req_pkt_xx = '0;
    @(posedge clk);
    #1;

    // Grant in the very cycle mem_req rises, then a line fill straddling the line.
    fixed_gnt = 0;
    gnt_wait  = 0;
    applyStimulus(1'b1, mkPkt(SZ_LINE, 1'b0, TYPE_LOAD, 32'h0000_1238, 64'h0));
    waitIdle();

    // Slow memory: grant after 5 cycles, read data 3 cycles later.
    fixed_gnt = 5;
    fixed_rd  = 3;
    gnt_wait  = 5;
    applyStimulus(1'b1, mkPkt(SZ_LWRD, 1'b0, TYPE_LOAD, 32'h8000_0004, 64'h0));
    waitIdle();
    fixed_gnt = -1;
    fixed_rd  = -1;

    // Store, then hammer a load every cycle so the earliest re-accept is pinned.
    applyStimulus(1'b1, mkPkt(SZ_WORD, 1'b0, TYPE_STORE, 32'h0000_0106, 64'hBEEF));
    for (int i = 0; i < 30 && busy; i++)
      applyStimulus(1'b1, mkPkt(SZ_QWRD, 1'b0, TYPE_LOAD, 32'h0000_2000, 64'h0));
    waitIdle();

    // Line fill followed by a request offered every cycle while busy.
    applyStimulus(1'b1, mkPkt(SZ_LINE, 1'b0, TYPE_LOAD, 32'h0000_3010, 64'h0));
    for (int i = 0; i < 40 && busy; i++)
      applyStimulus(1'b1, mkPkt(SZ_BYTE, 1'b0, TYPE_STORE, 32'h0000_3003, 64'h5A));
    waitIdle();

    // Reset while waiting for read data; the late rvalid must be dropped.
    applyStimulus(1'b1, mkPkt(SZ_LINE, 1'b0, TYPE_LOAD, 32'h0000_5000, 64'h0));
    for (int i = 0; i < 20 && !rd_pending; i++) applyStimulus(1'b0, '0);
    checkOutput("reached_mwait", rd_pending, 1'b1);
    reset = 1'b1;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    op_q.delete();
    resp_exp_q.delete();
    busy        = 0;
    release_cnt = 0;
    rd_pending  = 0;
    resp_due    = 0;
    checkOutput("midrst_resp", biu_resp_pkt_xx, '0);
    checkOutput("midrst_mem_req", mem_req, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = memWord(32'h0000_5000);
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    checkOutput("stale_rvalid_resp", biu_resp_pkt_xx[PKT_VLD_BIT], 1'b0);
    applyStimulus(1'b1, mkPkt(SZ_BYTE, 1'b0, TYPE_STORE, 32'h0000_0041, 64'h77));
    waitIdle();

    // Free-running random traffic with random memory latencies.
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, 9) < 6), randReq());
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
